acq_sequencer: RTL and testbench
================================

# acq_sequencer

Acquisition sequencer in the internal-clock domain, directly downstream of the SPI peripheral. It consumes the synchronized instruction pulses (`inst_start`, `inst_readout`, `inst_rst`), the held `clk_enable` level and the SPI-written configuration registers. It arms sampling, detects a masked and polarity-corrected discriminator trigger, and waits the programmed trigger delay before issuing a stop. It then streams the indices of hit channels to the readout path through a valid/ready handshake.

## Interface
- `NUM_CH`, 8: number of discriminator channels; mask, polarity and hit vectors are `NUM_CH` wide.
- `DELAY_W`, 8: width of the trigger-delay counter; matches the `trig_delay` register.

Ports:
- `iclk`  in  1  internal clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `inst_rst`  in  1  one-cycle instruction pulse from the instruction driver.
- `inst_start`  in  1  one-cycle instruction pulse.
- `inst_readout`  in  1  one-cycle instruction pulse.
- `clk_enable`  in  1  held START level.
- `trigger_channel_mask`  in  NUM_CH  enables the trigger for each channel (address 1).
- `disc_polarity`  in  NUM_CH  per-channel inversion of `disc_in` (address 61).
- `trig_delay`  in  DELAY_W  stop delay in `iclk` cycles (address 65).
- `disc_in`  in  NUM_CH  discriminator outputs, already synchronous to `iclk`.
- `rd_ready`  in  1  downstream readout accepts the current channel.
- `sampling`  out  1  high while armed or delaying.
- `stop_pulse`  out  1  one-cycle stop strobe to the sampling array.
- `hit_latched`  out  NUM_CH  masked hit pattern captured at trigger time.
- `rd_valid`  out  1  `rd_channel` is valid.
- `rd_channel`  out  3  index of the channel being read out.
- `rd_last`  out  1  the current beat is the final hit channel.
- `busy`  out  1  state is not IDLE.

## Operation
- `trig = |((disc_in ^ disc_polarity) & trigger_channel_mask)`.
- States: IDLE(0), ARMED(1), DELAY(2), STOPPED(3), READOUT(4).
- Priority in every state: `rst` first, then `inst_rst`, then the state's own transitions.
  - `inst_rst` forces IDLE at the next edge and clears `hit_latched`.
- IDLE:
  - `inst_start & clk_enable` → ARMED.
  - `inst_start` without `clk_enable` is ignored.
- ARMED (`sampling=1`):
  - If `!clk_enable` → IDLE. This wins over a simultaneous trigger.
  - Else if `trig`:
    - Capture `hit_latched <= masked hits`.
    - If `trig_delay==0`, go straight to STOPPED. Otherwise load `cnt <= trig_delay` and go to DELAY.
  - Else if `inst_readout` (software trigger):
    - `hit_latched <= trigger_channel_mask`.
    - Go to STOPPED with no delay.
- DELAY (`sampling=1`):
  - `cnt` decrements every edge.
  - At `cnt==1` → STOPPED.
  - `clk_enable` and `disc_in` are ignored in this state.
- STOPPED (`sampling=0`):
  - `stop_pulse=1` in the first cycle only.
  - `inst_readout` → READOUT, positioned on the lowest set bit of `hit_latched`. If `hit_latched==0`, go to IDLE instead with zero beats.
- READOUT:
  - `rd_valid=1`; `rd_channel` = current index.
  - `rd_last=1` when no higher bit of `hit_latched` is set.
  - On `rd_valid & rd_ready`, advance to the next higher set bit. After the last beat is accepted → IDLE.
  - `rd_channel` and `rd_last` stay stable while `rd_valid & !rd_ready`.
- `inst_start` outside IDLE is ignored. `inst_readout` is ignored in IDLE, DELAY and READOUT.
- `trig_delay` is sampled only at the trigger edge; later SPI writes do not affect a running delay.

## Timing
- Reset values: state IDLE, `cnt=0`, and all outputs 0 (`sampling`, `stop_pulse`, `hit_latched`, `rd_valid`, `rd_channel`, `rd_last`, `busy`).
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- `inst_start` sampled at edge N → `sampling=1` and `busy=1` from N+1.
- Trigger sampled at edge E0 → STOPPED and `stop_pulse` after edge E0+D (D = `trig_delay`, including D=0).
  - `sampling` falls in the same cycle that `stop_pulse` rises.
- `inst_readout` at edge R → first `rd_valid` beat after R.
- Throughput: one beat per cycle while `rd_ready=1`.
- `inst_rst` at edge K → all outputs at reset values after K.

## Structure
- Package `acq_seq_pkg`: state enum `acq_state_t` (3-bit encoding as listed above), `NUM_CH`, `DELAY_W`.
- Sub-module `next_hit_finder` (combinational): given `hit_latched` and a start index, returns the lowest set index ≥ start, plus a found flag. It serves both READOUT entry (start 0) and advance (start `cur+1`); `rd_last` is `!found` for `cur+1`.

## Test plan
- Mask `0x05`, polarity `0x00`, D=3, `inst_start`, then `disc_in=0x04` → `stop_pulse` 3 cycles after the trigger edge, `hit_latched=0x04`, `sampling` low from the stop cycle.
- Polarity `0xFF`, mask `0x81`, D=0, `disc_in` goes from `0xFF` to `0x7E` → immediate STOPPED, `hit_latched=0x81`.
- `hit_latched=0x92`, `inst_readout`, `rd_ready` toggling 1,0,1,1 → channels 1, 4, 7 in order; channel 4 held through the stall; `rd_last` only on 7; then IDLE.
- ARMED with `clk_enable` dropped in the same cycle as the trigger → IDLE, `hit_latched=0`, no `stop_pulse`.
- `inst_readout` in ARMED with mask `0x00` → STOPPED, then a second `inst_readout` → IDLE with no `rd_valid`.
- `inst_rst` mid-DELAY and mid-READOUT, and async `rst` mid-stall → all outputs 0 next edge (immediately for `rst`); a later `inst_start` re-arms normally.

Source files
------------

// File: rtl/acq_seq_pkg.sv
// Shared types and sizing for the acquisition sequencer.
// Pure declarations: no logic, no latency, no flow control.
package acq_seq_pkg;

    localparam int NUM_CH  = 8;
    localparam int DELAY_W = 8;
    localparam int CH_W    = $clog2(NUM_CH);
    // One extra bit so "current index + 1" can point past the top channel.
    localparam int IDX_W   = CH_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_STOPPED = 3'd3,
        ST_READOUT = 3'd4
    } acq_state_t;

endpackage

// File: rtl/acq_sequencer_next_hit_finder.sv
// Finds the lowest set bit of a hit vector at or above a start index.
// Purely combinational (zero latency), no flow control.
module next_hit_finder
    import acq_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] hits,
    input  logic [IDX_W-1:0]  start,
    output logic [CH_W-1:0]   idx,
    output logic              found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Walk downward so the lowest qualifying index is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hits[i] && (IDX_W'(i) >= start)) begin
                idx   = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// Arms sampling, waits the trigger delay, strobes stop, then streams hit channel indices.
// Outputs registered (one edge after the cause); readout holds its beat while rd_ready is low.
module acq_sequencer
    import acq_seq_pkg::*;
(
    input  logic               iclk,
    input  logic               rst,
    input  logic               inst_rst,
    input  logic               inst_start,
    input  logic               inst_readout,
    input  logic               clk_enable,
    input  logic [NUM_CH-1:0]  trigger_channel_mask,
    input  logic [NUM_CH-1:0]  disc_polarity,
    input  logic [DELAY_W-1:0] trig_delay,
    input  logic [NUM_CH-1:0]  disc_in,
    input  logic               rd_ready,
    output logic               sampling,
    output logic               stop_pulse,
    output logic [NUM_CH-1:0]  hit_latched,
    output logic               rd_valid,
    output logic [2:0]         rd_channel,
    output logic               rd_last,
    output logic               busy
);

    acq_state_t         state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]  hit_latched_q, hit_latched_d;
    logic [CH_W-1:0]    rd_channel_q, rd_channel_d;
    logic               rd_last_q, rd_last_d;
    logic               rd_valid_q, rd_valid_d;
    logic               sampling_q, sampling_d;
    logic               stop_pulse_q, stop_pulse_d;
    logic               busy_q, busy_d;

    logic [NUM_CH-1:0]  hit_mask;
    logic               trig;
    logic [IDX_W-1:0]   nxt_start, last_start;
    logic [CH_W-1:0]    nxt_idx, last_idx;
    logic               nxt_found, last_found;

    assign hit_mask = (disc_in ^ disc_polarity) & trigger_channel_mask;
    assign trig     = |hit_mask;

    // Entry scans from channel 0; during readout it scans from the channel after the current one.
    assign nxt_start  = (state_q == ST_READOUT) ? (IDX_W'(rd_channel_q) + IDX_W'(1)) : '0;
    assign last_start = IDX_W'(nxt_idx) + IDX_W'(1);

    next_hit_finder u_nxt (
        .hits  (hit_latched_q),
        .start (nxt_start),
        .idx   (nxt_idx),
        .found (nxt_found)
    );

    // Looks one beat further ahead so rd_last can be registered with the beat it describes.
    next_hit_finder u_last (
        .hits  (hit_latched_q),
        .start (last_start),
        .idx   (last_idx),
        .found (last_found)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hit_latched_d = hit_latched_q;
        rd_channel_d  = rd_channel_q;
        rd_last_d     = rd_last_q;

        if (inst_rst) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            hit_latched_d = '0;
            rd_channel_d  = '0;
            rd_last_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (inst_start && clk_enable) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (!clk_enable) begin
                        state_d = ST_IDLE;
                    end else if (trig) begin
                        hit_latched_d = hit_mask;
                        if (trig_delay == '0) begin
                            state_d = ST_STOPPED;
                        end else begin
                            cnt_d   = trig_delay;
                            state_d = ST_DELAY;
                        end
                    end else if (inst_readout) begin
                        hit_latched_d = trigger_channel_mask;
                        state_d       = ST_STOPPED;
                    end
                end
                ST_DELAY: begin
                    cnt_d = cnt_q - DELAY_W'(1);
                    if (cnt_q == DELAY_W'(1)) state_d = ST_STOPPED;
                end
                ST_STOPPED: begin
                    if (inst_readout) begin
                        if (nxt_found) begin
                            state_d      = ST_READOUT;
                            rd_channel_d = nxt_idx;
                            rd_last_d    = !last_found;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_READOUT: begin
                    if (rd_ready) begin
                        if (nxt_found) begin
                            rd_channel_d = nxt_idx;
                            rd_last_d    = !last_found;
                        end else begin
                            state_d      = ST_IDLE;
                            rd_channel_d = '0;
                            rd_last_d    = 1'b0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        sampling_d   = (state_d == ST_ARMED) || (state_d == ST_DELAY);
        stop_pulse_d = (state_d == ST_STOPPED) && (state_q != ST_STOPPED);
        rd_valid_d   = (state_d == ST_READOUT);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            hit_latched_q <= '0;
            rd_channel_q  <= '0;
            rd_last_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            sampling_q    <= 1'b0;
            stop_pulse_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hit_latched_q <= hit_latched_d;
            rd_channel_q  <= rd_channel_d;
            rd_last_q     <= rd_last_d;
            rd_valid_q    <= rd_valid_d;
            sampling_q    <= sampling_d;
            stop_pulse_q  <= stop_pulse_d;
            busy_q        <= busy_d;
        end
    end

    assign sampling    = sampling_q;
    assign stop_pulse  = stop_pulse_q;
    assign hit_latched = hit_latched_q;
    assign rd_valid    = rd_valid_q;
    assign rd_channel  = rd_channel_q;
    assign rd_last     = rd_last_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: inputs change 1ns after a rising edge, outputs checked before the next.
module tb_acq_sequencer;

    logic       iclk;
    logic       rst;
    logic       inst_rst;
    logic       inst_start;
    logic       inst_readout;
    logic       clk_enable;
    logic [7:0] trigger_channel_mask;
    logic [7:0] disc_polarity;
    logic [7:0] trig_delay;
    logic [7:0] disc_in;
    logic       rd_ready;
    logic       sampling;
    logic       stop_pulse;
    logic [7:0] hit_latched;
    logic       rd_valid;
    logic [2:0] rd_channel;
    logic       rd_last;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    acq_sequencer dut (
        .iclk                 (iclk),
        .rst                  (rst),
        .inst_rst             (inst_rst),
        .inst_start           (inst_start),
        .inst_readout         (inst_readout),
        .clk_enable           (clk_enable),
        .trigger_channel_mask (trigger_channel_mask),
        .disc_polarity        (disc_polarity),
        .trig_delay           (trig_delay),
        .disc_in              (disc_in),
        .rd_ready             (rd_ready),
        .sampling             (sampling),
        .stop_pulse           (stop_pulse),
        .hit_latched          (hit_latched),
        .rd_valid             (rd_valid),
        .rd_channel           (rd_channel),
        .rd_last              (rd_last),
        .busy                 (busy)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // {sampling, stop_pulse, hit_latched, rd_valid, rd_channel, rd_last, busy}
    function automatic logic [31:0] all_outs();
        return {16'd0, sampling, stop_pulse, hit_latched, rd_valid, rd_channel, rd_last, busy};
    endfunction

    initial begin
        rst = 1'b1; inst_rst = 0; inst_start = 0; inst_readout = 0; clk_enable = 0;
        trigger_channel_mask = 0; disc_polarity = 0; trig_delay = 0; disc_in = 0; rd_ready = 0;
        #2;
        chk("reset_outputs", all_outs(), 32'h0);
        #10 rst = 1'b0;
        tick();
        chk("idle_after_reset", all_outs(), 32'h0);

        // Hardware trigger with delay 3.
        clk_enable = 1; trigger_channel_mask = 8'h05; disc_polarity = 8'h00; trig_delay = 8'd3;
        inst_start = 1; tick(); inst_start = 0;
        chk("t1_sampling_armed", sampling, 1);
        chk("t1_busy_armed", busy, 1);
        disc_in = 8'h04; tick(); disc_in = 8'h00;
        chk("t1_hit_latched", hit_latched, 8'h04);
        chk("t1_no_stop_e0", stop_pulse, 0);
        tick();
        chk("t1_no_stop_e1", stop_pulse, 0);
        tick();
        chk("t1_no_stop_e2", stop_pulse, 0);
        chk("t1_sampling_e2", sampling, 1);
        tick();
        chk("t1_stop_e3", stop_pulse, 1);
        chk("t1_sampling_low_e3", sampling, 0);
        tick();
        chk("t1_stop_one_cycle", stop_pulse, 0);
        chk("t1_busy_stopped", busy, 1);
        inst_readout = 1; tick(); inst_readout = 0;
        chk("t1_rd_beat", {rd_valid, rd_channel, rd_last}, {1'b1, 3'd2, 1'b1});
        rd_ready = 1; tick(); rd_ready = 0;
        chk("t1_rd_done_idle", {rd_valid, busy}, 2'b00);

        // Inverted polarity, zero delay.
        disc_polarity = 8'hFF; trigger_channel_mask = 8'h81; trig_delay = 8'd0; disc_in = 8'hFF;
        inst_start = 1; tick(); inst_start = 0;
        tick();
        chk("t2_armed_no_trig", {sampling, stop_pulse}, 2'b10);
        disc_in = 8'h7E; tick(); disc_in = 8'hFF;
        chk("t2_immediate_stop", {sampling, stop_pulse}, 2'b01);
        chk("t2_hit_latched", hit_latched, 8'h81);
        inst_rst = 1; tick(); inst_rst = 0;
        chk("t2_inst_rst_stopped", all_outs(), 32'h0);

        // Software trigger, readout of 0x92 with a stall.
        disc_polarity = 8'h00; disc_in = 8'h00; trigger_channel_mask = 8'h92; trig_delay = 8'd5;
        inst_start = 1; tick(); inst_start = 0;
        inst_readout = 1; tick(); inst_readout = 0;
        chk("t3_sw_trig_stop", {sampling, stop_pulse, hit_latched}, {1'b0, 1'b1, 8'h92});
        tick();
        chk("t3_no_valid_in_stopped", rd_valid, 0);
        inst_readout = 1; rd_ready = 1; tick(); inst_readout = 0;
        chk("t3_beat_ch1", {rd_valid, rd_channel, rd_last}, {1'b1, 3'd1, 1'b0});
        rd_ready = 1; tick();
        chk("t3_beat_ch4", {rd_valid, rd_channel, rd_last}, {1'b1, 3'd4, 1'b0});
        rd_ready = 0; tick();
        chk("t3_stall_ch4", {rd_valid, rd_channel, rd_last}, {1'b1, 3'd4, 1'b0});
        rd_ready = 1; tick();
        chk("t3_beat_ch7_last", {rd_valid, rd_channel, rd_last}, {1'b1, 3'd7, 1'b1});
        rd_ready = 1; tick(); rd_ready = 0;
        chk("t3_idle_after_last", {rd_valid, busy}, 2'b00);
        chk("t3_hit_kept", hit_latched, 8'h92);

        // clk_enable drop beats a simultaneous trigger; start without enable ignored.
        inst_rst = 1; tick(); inst_rst = 0;
        chk("t4_inst_rst_clear", hit_latched, 8'h00);
        clk_enable = 0; inst_start = 1; tick(); inst_start = 0;
        chk("t4_start_no_enable", busy, 0);
        clk_enable = 1; trigger_channel_mask = 8'h05;
        inst_start = 1; tick(); inst_start = 0;
        disc_in = 8'h01; clk_enable = 0; tick(); disc_in = 8'h00; clk_enable = 1;
        chk("t4_drop_to_idle", all_outs(), 32'h0);
        tick();
        chk("t4_no_late_stop", stop_pulse, 0);

        // Software trigger with empty mask, readout yields no beats.
        trigger_channel_mask = 8'h00;
        inst_start = 1; tick(); inst_start = 0;
        inst_readout = 1; tick(); inst_readout = 0;
        chk("t5_stopped_empty", {stop_pulse, hit_latched, busy}, {1'b1, 8'h00, 1'b1});
        tick();
        inst_readout = 1; tick(); inst_readout = 0;
        chk("t5_idle_no_beat", {rd_valid, busy}, 2'b00);

        // inst_rst mid-delay.
        trigger_channel_mask = 8'h05; trig_delay = 8'd10;
        inst_start = 1; tick(); inst_start = 0;
        disc_in = 8'h04; tick(); disc_in = 8'h00;
        tick(); tick();
        inst_rst = 1; tick(); inst_rst = 0;
        chk("t6_inst_rst_delay", all_outs(), 32'h0);
        for (int i = 0; i < 10; i++) tick();
        chk("t6_delay_cancelled", {stop_pulse, busy}, 2'b00);

        // Delay sampled at trigger; later register write ignored. Then inst_rst mid-readout.
        trig_delay = 8'd2;
        inst_start = 1; tick(); inst_start = 0;
        chk("t7_rearm", {sampling, busy}, 2'b11);
        disc_in = 8'h04; tick(); disc_in = 8'h00; trig_delay = 8'd50;
        tick();
        chk("t7_no_stop_e1", stop_pulse, 0);
        tick();
        chk("t7_stop_e2", {sampling, stop_pulse}, 2'b01);
        inst_readout = 1; rd_ready = 0; tick(); inst_readout = 0;
        chk("t7_beat_ch2", {rd_valid, rd_channel, rd_last}, {1'b1, 3'd2, 1'b1});
        inst_rst = 1; tick(); inst_rst = 0;
        chk("t7_inst_rst_readout", all_outs(), 32'h0);

        // Async rst mid-stall.
        trigger_channel_mask = 8'h92;
        inst_start = 1; tick(); inst_start = 0;
        inst_readout = 1; tick();
        tick(); inst_readout = 0;
        rd_ready = 0; tick();
        chk("t8_stall_ch1", {rd_valid, rd_channel}, {1'b1, 3'd1});
        #2 rst = 1'b1;
        #1;
        chk("t8_async_rst", all_outs(), 32'h0);
        #2 rst = 1'b0;
        trigger_channel_mask = 8'h05;
        inst_start = 1; tick(); inst_start = 0;
        chk("t8_rearm_after_rst", {sampling, busy, stop_pulse}, 3'b110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
